// File: rtl/loop_seq.sv
// loop_seq: hardware loop sequencer between the instruction decoder and the PC mux.
// Keeps a nested stack of {remaining count, body address}. lp_end either
// decrements the innermost count and requests a branch back to the body, or
// pops the loop once its count is exhausted.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   lp_start/lp_count/lp_addr  open a loop (pulse + iteration count + body address)
//   lp_end               last body instruction reached (pulse)
//   ready                events accepted this cycle (low only during the JUMP cycle)
//   jmp/jmp_addr         one-cycle branch request and target
//   active/level         nesting status
//   cnt_top              remaining iterations of the innermost loop
//   err                  sticky protocol error
module loop_seq #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lp_start,
    input  logic [DW-1:0] lp_count,
    input  logic [AW-1:0] lp_addr,
    input  logic          lp_end,
    output logic          ready,
    output logic          jmp,
    output logic [AW-1:0] jmp_addr,
    output logic          active,
    output logic [LW-1:0] level,
    output logic [DW-1:0] cnt_top,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_JUMP} state_t;

    state_t        r_state, w_state_nxt;
    logic [LW-1:0] r_level;
    logic [DW-1:0] r_rem  [DEPTH];
    logic [AW-1:0] r_addr [DEPTH];
    logic          r_jmp;
    logic [AW-1:0] r_jmp_addr;
    logic          r_err;

    logic          w_ready, w_push, w_end, w_loop, w_pop, w_bad;
    logic [IW-1:0] w_top_idx, w_push_idx;
    logic [DW-1:0] w_top_rem;
    logic [AW-1:0] w_top_addr;

    assign w_ready    = (r_state != S_JUMP);
    assign w_top_idx  = IW'(r_level - LW'(1));
    assign w_push_idx = IW'(r_level);
    // Stack slots above the top may hold stale data; mask the view at level 0.
    assign w_top_rem  = (r_level == '0) ? '0 : r_rem[w_top_idx];
    assign w_top_addr = r_addr[w_top_idx];

    // An event is accepted only when it is the sole event, the sequencer is
    // ready and the stack has room / has an entry. Anything else is an error.
    assign w_push = w_ready && lp_start && !lp_end && (r_level < LW'(DEPTH));
    assign w_end  = w_ready && lp_end && !lp_start && (r_level != '0);
    assign w_loop = w_end && (w_top_rem != '0);
    assign w_pop  = w_end && (w_top_rem == '0);
    assign w_bad  = (lp_start || lp_end) && !w_push && !w_end;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_JUMP:  w_state_nxt = S_RUN;
            default: begin
                if (w_push)
                    w_state_nxt = S_RUN;
                else if (w_loop)
                    w_state_nxt = S_JUMP;
                else if (w_pop)
                    w_state_nxt = (r_level == LW'(1)) ? S_IDLE : S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= '0;
            r_jmp      <= 1'b0;
            r_jmp_addr <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rem[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_jmp <= w_loop;
            if (w_bad)
                r_err <= 1'b1;
            if (w_push) begin
                // A zero count runs the body once, same as a count of one.
                r_rem[w_push_idx]  <= (lp_count == '0) ? '0 : lp_count - DW'(1);
                r_addr[w_push_idx] <= lp_addr;
                r_level            <= r_level + LW'(1);
            end
            if (w_loop) begin
                r_rem[w_top_idx] <= w_top_rem - DW'(1);
                r_jmp_addr       <= w_top_addr;
            end
            if (w_pop)
                r_level <= r_level - LW'(1);
        end
    end

    assign ready    = w_ready;
    assign jmp      = r_jmp;
    assign jmp_addr = r_jmp_addr;
    assign active   = (r_level != '0);
    assign level    = r_level;
    assign cnt_top  = w_top_rem;
    assign err      = r_err;

endmodule
